// File: rtl/cpu_pkg.sv
// Shared CPU definitions: IR field positions, link register and the opcodes
// decoded by the control unit in fetch2.
package cpu_pkg;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI  = 26;
  localparam int RA_LO  = 23;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;
  localparam int C_HI   = 18;
  localparam int C_LO   = 0;

  localparam logic [3:0] LINK_REG = 4'd15;

  localparam logic [4:0] OPC_NOP  = 5'd0;
  localparam logic [4:0] OPC_LD   = 5'd1;
  localparam logic [4:0] OPC_LDR  = 5'd2;
  localparam logic [4:0] OPC_ST   = 5'd3;
  localparam logic [4:0] OPC_STR  = 5'd4;
  localparam logic [4:0] OPC_LA   = 5'd5;
  localparam logic [4:0] OPC_LAR  = 5'd6;
  localparam logic [4:0] OPC_BR   = 5'd8;
  localparam logic [4:0] OPC_BRL  = 5'd9;
  localparam logic [4:0] OPC_ADD  = 5'd12;
  localparam logic [4:0] OPC_SUB  = 5'd14;
  localparam logic [4:0] OPC_HALT = 5'd31;

endpackage

// File: rtl/register32.sv
// Plain load-enabled register with synchronous active-high clear.
module register32 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/gp_register_bank.sv
// Instruction register plus 16-entry general-purpose register file with
// gra/grb/grc select-and-encode, base-address R0 gating and C sign extension.
module gp_register_bank
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int C_W      = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              ir_in,
  input  logic              gra,
  input  logic              grb,
  input  logic              grc,
  input  logic              r_in,
  input  logic              r_out,
  input  logic              ba_out,
  output logic [DATA_W-1:0] ir_data,
  output logic [DATA_W-1:0] reg_data,
  output logic              reg_drive,
  output logic [DATA_W-1:0] c_sign_ext,
  output logic [4:0]        opcode
);

  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [3:0]        field_sel;
  logic              any_sel;
  logic [3:0]        rd_sel;
  logic [3:0]        wr_sel;

  register32 #(.W(DATA_W)) u_ir (
    .clk   (clk),
    .reset (reset),
    .load  (ir_in),
    .d     (bus_in),
    .q     (ir)
  );

  // Fixed priority gra > grb > grc; with no select, reads hit R0 and writes
  // go to the link register (jal).
  always_comb begin
    field_sel = '0;
    any_sel   = 1'b1;
    if (gra)
      field_sel = ir[RA_HI:RA_LO];
    else if (grb)
      field_sel = ir[RB_HI:RB_LO];
    else if (grc)
      field_sel = ir[RC_HI:RC_LO];
    else
      any_sel = 1'b0;
  end

  assign rd_sel = any_sel ? field_sel : 4'd0;
  assign wr_sel = any_sel ? field_sel : LINK_REG;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
    register32 #(.W(DATA_W)) u_reg (
      .clk   (clk),
      .reset (reset),
      .load  (r_in && (wr_sel == 4'(i))),
      .d     (bus_in),
      .q     (regs[i])
    );
  end

  always_comb begin
    reg_drive = r_out | ba_out;
    reg_data  = '0;
    if (reg_drive && !(ba_out && rd_sel == 4'd0))
      reg_data = regs[rd_sel];
  end

  assign ir_data    = ir;
  assign opcode     = ir[OPC_HI:OPC_LO];
  assign c_sign_ext = {{(DATA_W-C_W){ir[C_HI]}}, ir[C_HI:C_LO]};

endmodule

// File: tb/tb_gp_register_bank.sv
// Self-checking bench for gp_register_bank against a behavioural model of the
// IR and register file.
module tb_gp_register_bank;

  logic        clk = 1'b0;
  logic        reset, ir_in, gra, grb, grc, r_in, r_out, ba_out;
  logic [31:0] bus_in;
  logic [31:0] ir_data, reg_data, c_sign_ext;
  logic        reg_drive;
  logic [4:0]  opcode;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_regs [16];
  logic [31:0] m_ir;

  gp_register_bank dut (
    .clk        (clk),
    .reset      (reset),
    .bus_in     (bus_in),
    .ir_in      (ir_in),
    .gra        (gra),
    .grb        (grb),
    .grc        (grc),
    .r_in       (r_in),
    .r_out      (r_out),
    .ba_out     (ba_out),
    .ir_data    (ir_data),
    .reg_data   (reg_data),
    .reg_drive  (reg_drive),
    .c_sign_ext (c_sign_ext),
    .opcode     (opcode)
  );

  always #5 clk = ~clk;

  function automatic int field_index(input logic [31:0] ir, input bit a, input bit b,
                                     input bit c, input int none_idx);
    if (a) return int'(ir[26:23]);
    if (b) return int'(ir[22:19]);
    if (c) return int'(ir[18:15]);
    return none_idx;
  endfunction

  function automatic logic [31:0] exp_read();
    int idx = field_index(m_ir, gra, grb, grc, 0);
    if (!(r_out || ba_out)) return 32'h0;
    if (ba_out && idx == 0) return 32'h0;
    return m_regs[idx];
  endfunction

  function automatic logic [31:0] exp_sext();
    int c = int'(m_ir[18:0]);
    if (c >= (1 << 18)) c = c - (1 << 19);
    return 32'(c);
  endfunction

  task automatic idle();
    reset = 0; ir_in = 0; gra = 0; grb = 0; grc = 0;
    r_in = 0; r_out = 0; ba_out = 0; bus_in = 32'h0;
  endtask

  // One rising edge; the model applies the same edge using pre-edge state.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
      m_ir = 32'h0;
    end else begin
      if (r_in) m_regs[field_index(m_ir, gra, grb, grc, 15)] = bus_in;
      if (ir_in) m_ir = bus_in;
    end
    #1;
  endtask

  task automatic load_ir(input logic [31:0] v);
    idle(); ir_in = 1; bus_in = v; tick(); idle();
  endtask

  task automatic write_ra(input int k, input logic [31:0] v);
    load_ir(32'(k) << 23);
    gra = 1; r_in = 1; bus_in = v; tick(); idle();
  endtask

  // Fetch register k through the ports (overwrites IR).
  task automatic peek(input int k, output logic [31:0] v);
    load_ir(32'(k) << 23);
    gra = 1; r_out = 1; #1; v = reg_data; idle();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    idle(); reset = 1; tick(); idle();
    checks++; if (ir_data !== 32'h0) begin errors++; $display("FAIL reset_ir got=%h exp=%h", ir_data, 32'h0); end
    checks++; if (opcode !== 5'h0) begin errors++; $display("FAIL reset_opcode got=%h exp=%h", opcode, 5'h0); end
    checks++; if (c_sign_ext !== 32'h0) begin errors++; $display("FAIL reset_cext got=%h exp=%h", c_sign_ext, 32'h0); end
    write_ra(3, 32'h1234);
    peek(3, v);
    checks++; if (v !== 32'h1234) begin errors++; $display("FAIL pre_reset_r3 got=%h exp=%h", v, 32'h1234); end
    idle(); reset = 1; tick(); idle();
    checks++; if (ir_data !== 32'h0) begin errors++; $display("FAIL reset2_ir got=%h exp=%h", ir_data, 32'h0); end
    peek(3, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_r3 got=%h exp=%h", v, 32'h0); end
  endtask

  task automatic test_ir_read();
    load_ir(32'h18918000);
    checks++; if (opcode !== 5'b00011) begin errors++; $display("FAIL ir_opcode got=%h exp=%h", opcode, 5'b00011); end
    grb = 1; r_in = 1; bus_in = 32'd5; tick(); idle();
    grc = 1; r_in = 1; bus_in = 32'd7; tick(); idle();
    grb = 1; r_out = 1; #1;
    checks++; if (reg_data !== 32'd5) begin errors++; $display("FAIL read_rb got=%h exp=%h", reg_data, 32'd5); end
    checks++; if (reg_drive !== 1'b1) begin errors++; $display("FAIL drive_rb got=%b exp=1", reg_drive); end
    idle(); grc = 1; r_out = 1; #1;
    checks++; if (reg_data !== 32'd7) begin errors++; $display("FAIL read_rc got=%h exp=%h", reg_data, 32'd7); end
    idle(); gra = 1; r_in = 1; r_out = 1; bus_in = 32'd12; #1;
    checks++; if (reg_data !== exp_read()) begin errors++; $display("FAIL no_bypass got=%h exp=%h", reg_data, exp_read()); end
    tick(); #1;
    checks++; if (reg_data !== 32'd12) begin errors++; $display("FAIL write_ra got=%h exp=%h", reg_data, 32'd12); end
    idle(); #1;
    checks++; if (reg_data !== 32'h0 || reg_drive !== 1'b0) begin errors++; $display("FAIL idle_read got=%h/%b exp=0/0", reg_data, reg_drive); end
  endtask

  task automatic test_base_addr();
    write_ra(0, 32'hDEADBEEF);
    load_ir(32'h0);
    grb = 1; ba_out = 1; #1;
    checks++; if (reg_data !== 32'h0) begin errors++; $display("FAIL ba_r0 got=%h exp=%h", reg_data, 32'h0); end
    checks++; if (reg_drive !== 1'b1) begin errors++; $display("FAIL ba_drive got=%b exp=1", reg_drive); end
    idle(); grb = 1; r_out = 1; #1;
    checks++; if (reg_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rout_r0 got=%h exp=%h", reg_data, 32'hDEADBEEF); end
    idle();
    write_ra(7, 32'hCAFE0007);
    load_ir(32'd7 << 19);
    grb = 1; ba_out = 1; #1;
    checks++; if (reg_data !== 32'hCAFE0007) begin errors++; $display("FAIL ba_r7 got=%h exp=%h", reg_data, 32'hCAFE0007); end
    idle();
  endtask

  task automatic test_sign_ext();
    load_ir(32'h0007FFFF);
    checks++; if (c_sign_ext !== 32'hFFFFFFFF) begin errors++; $display("FAIL sext_neg got=%h exp=%h", c_sign_ext, 32'hFFFFFFFF); end
    load_ir(32'h0003FFFF);
    checks++; if (c_sign_ext !== 32'h0003FFFF) begin errors++; $display("FAIL sext_pos got=%h exp=%h", c_sign_ext, 32'h0003FFFF); end
    load_ir(32'hF8040000);
    checks++; if (c_sign_ext !== 32'hFFFC0000) begin errors++; $display("FAIL sext_min got=%h exp=%h", c_sign_ext, 32'hFFFC0000); end
    checks++; if (opcode !== 5'h1F) begin errors++; $display("FAIL opcode_max got=%h exp=%h", opcode, 5'h1F); end
  endtask

  task automatic test_link_priority();
    logic [31:0] v;
    logic [31:0] expect_regs [16];
    load_ir(32'h0);
    for (int i = 0; i < 16; i++) expect_regs[i] = m_regs[i];
    expect_regs[15] = 32'h40;
    r_in = 1; bus_in = 32'h40; tick(); idle();
    load_ir((32'd4 << 23) | (32'd5 << 19));
    expect_regs[4] = 32'hA5A50004;
    gra = 1; grb = 1; r_in = 1; bus_in = 32'hA5A50004; tick(); idle();
    for (int k = 0; k < 16; k++) begin
      peek(k, v);
      checks++; if (v !== expect_regs[k]) begin errors++; $display("FAIL link_prio_r%0d got=%h exp=%h", k, v, expect_regs[k]); end
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] v, nv, old9;
    load_ir(32'd6 << 23);
    old9 = m_regs[9];
    nv = (32'd9 << 23) | ($urandom & 32'h007FFFFF) | 32'h00000001;
    ir_in = 1; gra = 1; r_in = 1; bus_in = nv; tick(); idle();
    checks++; if (ir_data !== nv) begin errors++; $display("FAIL simul_ir got=%h exp=%h", ir_data, nv); end
    peek(6, v);
    checks++; if (v !== nv) begin errors++; $display("FAIL simul_r6 got=%h exp=%h", v, nv); end
    peek(9, v);
    checks++; if (v !== old9) begin errors++; $display("FAIL simul_r9 got=%h exp=%h", v, old9); end
    load_ir(32'd2 << 23);
    reset = 1; ir_in = 1; gra = 1; r_in = 1; bus_in = 32'h5555AAAA; tick(); idle();
    checks++; if (ir_data !== 32'h0) begin errors++; $display("FAIL rst_ir got=%h exp=%h", ir_data, 32'h0); end
    for (int k = 0; k < 16; k++) begin
      peek(k, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_r%0d got=%h exp=%h", k, v, 32'h0); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      reset  = ($urandom_range(0, 49) == 0);
      ir_in  = ($urandom_range(0, 3) == 0);
      gra    = 1'($urandom); grb = 1'($urandom); grc = 1'($urandom);
      r_in   = 1'($urandom);
      r_out  = 1'($urandom); ba_out = ($urandom_range(0, 2) == 0);
      bus_in = ($urandom_range(0, 7) == 0) ? 32'(n & 1) << 18 : $urandom;
      #1;
      checks++; if (reg_data !== exp_read()) begin errors++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, reg_data, exp_read()); end
      checks++; if (reg_drive !== (r_out | ba_out)) begin errors++; $display("FAIL rnd_drive n=%0d got=%b exp=%b", n, reg_drive, r_out | ba_out); end
      checks++; if (ir_data !== m_ir) begin errors++; $display("FAIL rnd_ir n=%0d got=%h exp=%h", n, ir_data, m_ir); end
      checks++; if (c_sign_ext !== exp_sext()) begin errors++; $display("FAIL rnd_cext n=%0d got=%h exp=%h", n, c_sign_ext, exp_sext()); end
      checks++; if (opcode !== 5'(m_ir >> 27)) begin errors++; $display("FAIL rnd_opcode n=%0d got=%h exp=%h", n, opcode, 5'(m_ir >> 27)); end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
    m_ir = 32'h0;
    #2;
    test_reset();
    test_ir_read();
    test_base_addr();
    test_sign_ext();
    test_link_priority();
    test_simultaneous();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
